md_unit: RTL

- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Owns the HI and LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Produces the BUSY signal that the hazard unit uses to stall md-class instructions (mult/div/mfhi/mflo/mthi/mtlo) in D.
- HI/LO read (mfhi/mflo) is muxed outside this block from the HI/LO outputs.

---
 rtl/md_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO and raises BUSY for a fixed number of cycles per mult/div.
//
// Handshake: START is a one-cycle request, honoured only while BUSY=0
// (state IDLE). mult/div requests raise BUSY in the following cycle. BUSY
// then stays high for exactly MULT_CYCLES or DIV_CYCLES cycles, and the new
// HI/LO are visible in the first cycle with BUSY low again. A START seen
// while BUSY=1, including on the completing edge, is dropped.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  MD_OP,
  input  logic [31:0] SRC_A,
  input  logic [31:0] SRC_B,
  output logic        BUSY,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  // op_q[1]: 1=divide, 0=multiply; op_q[0]: 1=unsigned, 0=signed
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        is_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;

  assign state_dbg = (state == RUN);

  // Result datapath on the latched operands. Division works on magnitudes
  // so that 0x80000000 / -1 wraps to 0x80000000 with remainder 0 without
  // relying on signed-overflow behaviour of the divider.
  always_comb begin
    is_signed   = ~op_q[0];
    ext_a       = {{32{a_q[31] & is_signed}}, a_q};
    ext_b       = {{32{b_q[31] & is_signed}}, b_q};
    prod        = ext_a * ext_b;
    a_neg       = is_signed & a_q[31];
    b_neg       = is_signed & b_q[31];
    a_mag       = a_neg ? (32'd0 - a_q) : a_q;
    b_mag       = b_neg ? (32'd0 - b_q) : b_q;
    div_by_zero = op_q[1] & (b_q == 32'd0);
    q_mag       = 32'd0;
    r_mag       = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
    res_hi = op_q[1] ? rem  : prod[63:32];
    res_lo = op_q[1] ? quot : prod[31:0];
  end

  // Control FSM plus HI/LO update; HI/LO change only on mthi/mtlo in IDLE
  // or on the final RUN edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      cnt   <= 4'd0;
      op_q  <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            case (MD_OP)
              3'd0, 3'd1: begin
                op_q  <= MD_OP[1:0];
                a_q   <= SRC_A;
                b_q   <= SRC_B;
                cnt   <= MULT_CNT;
                state <= RUN;
                BUSY  <= 1'b1;
              end
              3'd2, 3'd3: begin
                op_q  <= MD_OP[1:0];
                a_q   <= SRC_A;
                b_q   <= SRC_B;
                cnt   <= DIV_CNT;
                state <= RUN;
                BUSY  <= 1'b1;
              end
              3'd4: HI <= SRC_A;
              3'd5: LO <= SRC_A;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            if (!div_by_zero) begin
              HI <= res_hi;
              LO <= res_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
